// File: rtl/dsp_pkg.sv
// Shared constants and types for the DSP core register-file write side.
package dsp_pkg;
   localparam int REG_ADDR_W = 4;
   localparam int NUM_REGS   = 16;
   localparam int DW         = 32;

   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 4'd0;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [DW-1:0]         data;
   } wr_req_t;
endpackage

// File: rtl/dsp_wb_fifo.sv
// Synchronous FIFO with a first-word-fall-through head; holds buffered MAC results.
module dsp_wb_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 36
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [W-1:0]           push_data,
   input  logic                   pop,
   output logic [W-1:0]           head,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Power-of-two depth lets the pointers wrap by plain overflow.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end
endmodule

// File: rtl/dsp_writeback.sv
// Register-file write master: ALU/MAC arbitration with starvation guard,
// registered write port, and pending-destination scoreboard for MAC hazards.
module dsp_writeback
   import dsp_pkg::*;
#(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 3,
   parameter int DW           = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   alu_valid,
   output logic                   alu_ready,
   input  logic [REG_ADDR_W-1:0]  alu_rd,
   input  logic [DW-1:0]          alu_data,
   input  logic                   mac_valid,
   output logic                   mac_ready,
   input  logic [REG_ADDR_W-1:0]  mac_rd,
   input  logic [DW-1:0]          mac_data,
   input  logic                   issue_valid,
   input  logic [REG_ADDR_W-1:0]  issue_rd,
   output logic                   we,
   output logic [REG_ADDR_W-1:0]  rw,
   output logic [DW-1:0]          wdata,
   output logic [NUM_REGS-1:0]    pending,
   output logic [$clog2(DEPTH):0] fifo_count
);
   localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam int FW = REG_ADDR_W + DW;

   logic                  fifo_full;
   logic                  fifo_empty;
   logic [FW-1:0]         fifo_head;
   logic [REG_ADDR_W-1:0] head_rd;
   logic [DW-1:0]         head_data;
   logic                  force_mac;
   logic                  alu_win;
   logic                  pop;
   logic                  win_valid;
   logic [REG_ADDR_W-1:0] win_rd;
   logic [DW-1:0]         win_data;
   logic [SW-1:0]         starve_cnt;
   logic [SW-1:0]         starve_nxt;
   logic [NUM_REGS-1:0]   pending_nxt;

   // Handshake: a transfer happens in any cycle where valid && ready are both
   // high at the rising edge; ready never depends on same-cycle valid, and a
   // source seeing valid && !ready must hold its payload until accepted.
   assign mac_ready = !fifo_full;

   dsp_wb_fifo #(.DEPTH(DEPTH), .W(FW)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (mac_valid && mac_ready),
      .push_data ({mac_rd, mac_data}),
      .pop       (pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign {head_rd, head_data} = fifo_head;

   assign force_mac = !fifo_empty && (starve_cnt >= SW'(STARVE_LIMIT));
   assign alu_ready = !force_mac;
   assign alu_win   = alu_valid && !force_mac;
   assign pop       = !alu_win && !fifo_empty;
   assign win_valid = alu_win || pop;
   assign win_rd    = alu_win ? alu_rd : head_rd;
   assign win_data  = alu_win ? alu_data : head_data;

   always_comb begin
      starve_nxt = starve_cnt;
      if (fifo_empty || pop) begin
         starve_nxt = '0;
      end else if (alu_win && (starve_cnt < SW'(STARVE_LIMIT))) begin
         starve_nxt = starve_cnt + SW'(1);
      end
   end

   // A set from a new issue overrides the clear from a same-cycle pop.
   always_comb begin
      pending_nxt = pending;
      if (pop) pending_nxt[head_rd] = 1'b0;
      if (issue_valid && (issue_rd != REG_ZERO)) pending_nxt[issue_rd] = 1'b1;
      pending_nxt[REG_ZERO] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         starve_cnt <= '0;
         pending    <= '0;
         we         <= 1'b0;
         rw         <= '0;
         wdata      <= '0;
      end else begin
         starve_cnt <= starve_nxt;
         pending    <= pending_nxt;
         // r0 winners are consumed but never reach the register file.
         we         <= win_valid && (win_rd != REG_ZERO);
         if (win_valid) begin
            rw    <= win_rd;
            wdata <= win_data;
         end
      end
   end
endmodule

// File: tb/tb_dsp_writeback.sv
// Directed + randomized bench for dsp_writeback against a queue-based reference model.
module tb_dsp_writeback;
   import dsp_pkg::*;

   localparam int DEPTH        = 4;
   localparam int STARVE_LIMIT = 3;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   alu_valid;
   logic                   alu_ready;
   logic [3:0]             alu_rd;
   logic [31:0]            alu_data;
   logic                   mac_valid;
   logic                   mac_ready;
   logic [3:0]             mac_rd;
   logic [31:0]            mac_data;
   logic                   issue_valid;
   logic [3:0]             issue_rd;
   logic                   we;
   logic [3:0]             rw;
   logic [31:0]            wdata;
   logic [15:0]            pending;
   logic [$clog2(DEPTH):0] fifo_count;

   dsp_writeback #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT), .DW(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
      .mac_valid(mac_valid), .mac_ready(mac_ready), .mac_rd(mac_rd), .mac_data(mac_data),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .we(we), .rw(rw), .wdata(wdata), .pending(pending), .fifo_count(fifo_count)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: got no_finish expected finish");
      $fatal(1, "timeout");
   end

   int n_cmp = 0;
   int n_err = 0;

   // reference model state
   wr_req_t     mac_q[$];
   int          streak;
   logic [15:0] m_pend;
   logic        m_we;
   logic [3:0]  m_rw;
   logic [31:0] m_wd;
   logic [35:0] exp_q[$];

   logic c_alu_acc, c_mac_acc;
   logic s_alu_ready, s_mac_ready;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock cycle: drive, check handshake, advance model, check write port.
   task automatic cyc(input logic av, input logic [3:0] ard, input logic [31:0] ad,
                      input logic mv, input logic [3:0] mrd, input logic [31:0] md,
                      input logic iv, input logic [3:0] ird);
      logic    force_m;
      logic    pop_m;
      logic    has_win;
      wr_req_t win;
      alu_valid = av;  alu_rd = ard;  alu_data = ad;
      mac_valid = mv;  mac_rd = mrd;  mac_data = md;
      issue_valid = iv; issue_rd = ird;
      #1;
      force_m   = (mac_q.size() != 0) && (streak >= STARVE_LIMIT);
      c_alu_acc = av && !force_m;
      pop_m     = !c_alu_acc && (mac_q.size() != 0);
      c_mac_acc = mv && (mac_q.size() < DEPTH);
      s_alu_ready = alu_ready;
      s_mac_ready = mac_ready;
      if (rst_n) begin
         check("alu_ready", alu_ready, !force_m);
         check("mac_ready", mac_ready, mac_q.size() < DEPTH);
      end
      @(posedge clk);
      has_win = 1'b0;
      win     = '0;
      if (!rst_n) begin
         mac_q.delete();
         exp_q.delete();
         streak = 0;
         m_pend = '0;
         m_we = 1'b0; m_rw = '0; m_wd = '0;
      end else begin
         if (c_alu_acc) begin
            has_win = 1'b1;
            win.rd = ard; win.data = ad;
            streak = (mac_q.size() != 0) ? streak + 1 : 0;
         end else if (pop_m) begin
            has_win = 1'b1;
            win = mac_q.pop_front();
            m_pend[win.rd] = 1'b0;
            streak = 0;
         end else begin
            streak = 0;
         end
         if (c_mac_acc) mac_q.push_back('{rd: mrd, data: md});
         if (iv && ird != 4'd0) m_pend[ird] = 1'b1;
         m_we = has_win && (win.rd != 4'd0);
         if (has_win) begin
            m_rw = win.rd; m_wd = win.data;
         end
         if (m_we) exp_q.push_back({win.rd, win.data});
      end
      #1;
      check("we", we, m_we);
      check("pending", pending, m_pend);
      check("fifo_count", fifo_count, mac_q.size());
      if (!rst_n) begin
         check("rst_rw", rw, 0);
         check("rst_wdata", wdata, 0);
      end
      if (we) begin
         if (exp_q.size() == 0) check("unexpected_write", {rw, wdata}, 0);
         else check("write", {rw, wdata}, exp_q.pop_front());
      end
      @(negedge clk);
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      int          k;
      int          j;
      logic        full_seen;
      logic        ha, hm, hi;
      logic [3:0]  hard, hmrd, hird;
      logic [31:0] had, hmd;

      streak = 0; m_pend = '0; m_we = 0; m_rw = 0; m_wd = 0;
      rst_n = 1'b0;
      alu_valid = 0; alu_rd = 0; alu_data = 0;
      mac_valid = 0; mac_rd = 0; mac_data = 0;
      issue_valid = 0; issue_rd = 0;
      @(negedge clk);
      idle();
      idle();
      rst_n = 1'b1;

      // ALU only
      cyc(1, 4'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
      check("tp_alu_we", we, 1);
      check("tp_alu_rw", rw, 5);
      check("tp_alu_wdata", wdata, 32'hDEADBEEF);
      idle();

      // MAC with scoreboard
      cyc(0, 0, 0, 0, 0, 0, 1, 4'd7);
      check("tp_pend7_set", pending[7], 1);
      idle();
      idle();
      cyc(0, 0, 0, 1, 4'd7, 32'h12345678, 0, 0);
      check("tp_pend7_held", pending[7], 1);
      idle();
      check("tp_mac_we", we, 1);
      check("tp_mac_wdata", wdata, 32'h12345678);
      check("tp_pend7_clr", pending[7], 0);

      // starvation: one MAC entry against a continuous ALU stream
      k = 0;
      for (int i = 0; i < 6; i++) begin
         cyc(1, 4'd1, 32'hA0 + k, i == 0, 4'd9, 32'h9999, 0, 0);
         if (c_alu_acc) k++;
         if (i == 3) check("tp_starve_alu_ok", s_alu_ready, 1);
         if (i == 4) begin
            check("tp_starve_force", s_alu_ready, 0);
            check("tp_starve_rw", rw, 9);
         end
         if (i == 5) check("tp_starve_resume", s_alu_ready, 1);
      end
      idle();

      // FIFO full: five MAC results while the ALU saturates the port
      k = 0; j = 0; full_seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (j < 5 || mac_q.size() != 0) begin
            cyc(1, 4'd2, 32'hB000 + k, j < 5, 4'(j + 10), 32'hC000 + j, 0, 0);
            if (c_alu_acc) k++;
            if (c_mac_acc) j++;
            if (!s_mac_ready) full_seen = 1'b1;
         end
      end
      check("tp_full_seen", full_seen, 1);
      check("tp_full_all_pushed", j, 5);
      idle();

      // r0 writes
      cyc(1, 4'd0, 32'hFFFFFFFF, 0, 0, 0, 0, 0);
      check("tp_r0_alu_we", we, 0);
      cyc(0, 0, 0, 1, 4'd0, 32'h55, 0, 0);
      idle();
      check("tp_r0_mac_we", we, 0);
      check("tp_r0_pend", pending, 0);

      // set wins over clear, then reset with entries buffered
      cyc(0, 0, 0, 0, 0, 0, 1, 4'd3);
      cyc(0, 0, 0, 1, 4'd3, 32'h33, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 1, 4'd3);
      check("tp_setclr_pend3", pending[3], 1);
      cyc(1, 4'd4, 32'h44, 1, 4'd6, 32'h66, 0, 0);
      cyc(1, 4'd4, 32'h45, 1, 4'd8, 32'h88, 0, 0);
      check("tp_buffered2", fifo_count, 2);
      rst_n = 1'b0;
      idle();
      rst_n = 1'b1;
      check("tp_rst_count", fifo_count, 0);
      check("tp_rst_pend", pending, 0);
      check("tp_rst_we", we, 0);

      // randomized traffic with held payloads on unaccepted sources
      ha = 0; hm = 0; hard = 0; had = 0; hmrd = 0; hmd = 0;
      for (int n = 0; n < 400; n++) begin
         if (!ha && $urandom_range(0, 3) != 0) begin
            ha = 1; hard = 4'($urandom_range(0, 15)); had = $urandom;
         end
         if (!hm && $urandom_range(0, 2) == 0) begin
            hm = 1; hmrd = 4'($urandom_range(0, 15)); hmd = $urandom;
         end
         hi   = ($urandom_range(0, 3) == 0);
         hird = 4'($urandom_range(0, 15));
         rst_n = ($urandom_range(0, 149) != 0);
         cyc(ha, hard, had, hm, hmrd, hmd, hi, hird);
         if (c_alu_acc) ha = 0;
         if (c_mac_acc) hm = 0;
         if (!rst_n) begin
            ha = 0; hm = 0; rst_n = 1'b1;
         end
      end
      rst_n = 1'b1;
      for (int n = 0; n < 8; n++) idle();
      check("drain_fifo_count", fifo_count, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/dsp_writeback.md
Name: dsp_writeback

Overview:
Write-side master for the DSP core's 16x32 register file. It arbitrates ALU results (single-cycle) and MAC results (multi-cycle, buffered) onto the single register-file write port (we/rw/wdata). It also keeps a pending-destination scoreboard so issue logic can stall on MAC hazards. It sits between the execute units and the register file, and its outputs drive the register file's write port directly.

Parameters:
DEPTH, 4, MAC result FIFO entries; power of two, 2..16.
STARVE_LIMIT, 3, consecutive cycles a non-empty FIFO head may lose to the ALU before it is forced.
DW, 32, data width.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
alu_valid  in  1  ALU result present
alu_ready  out  1  ALU result accepted this cycle
alu_rd  in  4  ALU destination register
alu_data  in  DW  ALU result
mac_valid  in  1  MAC result present
mac_ready  out  1  FIFO can accept
mac_rd  in  4  MAC destination register
mac_data  in  DW  MAC result
issue_valid  in  1  MAC op issued this cycle
issue_rd  in  4  destination of the issued MAC op
we  out  1  register-file write enable
rw  out  4  register-file write address
wdata  out  DW  register-file write data
pending  out  16  bit n=1: a MAC write to rn is outstanding
fifo_count  out  log2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst_n=0 at posedge): we=0, rw=0, wdata=0, pending=0, FIFO empty (count=0, pointers=0), starve counter=0.
- MAC FIFO:
  - mac_ready = (count < DEPTH). It depends only on registered count, not on a same-cycle pop.
  - Push occurs when mac_valid && mac_ready.
  - When full, mac_ready=0, no push, and no data is lost (the source holds).
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
- Arbitration (combinational select, registered output):
  - force = FIFO non-empty && starve_cnt >= STARVE_LIMIT.
  - alu_ready = !force.
  - If alu_valid && !force: ALU wins.
  - Else if FIFO non-empty: pop the head.
  - Else: no write.
- Starve counter: increments when the FIFO is non-empty and the ALU wins. Clears on any FIFO pop or when the FIFO is empty. Saturates at STARVE_LIMIT.
- Output stage:
  - The selected winner is registered into we/rw/wdata on the next posedge.
  - Latency: input accepted at cycle N appears on the write port in cycle N+1.
  - With no winner, we=0; rw/wdata hold their previous values.
- r0 suppression: a winner with rd==0 is consumed (ready/pop happen normally) but produces we=0.
- Scoreboard:
  - issue_valid && issue_rd!=0 sets pending[issue_rd] at the next edge.
  - A FIFO pop with destination r clears pending[r] at the same edge the write is registered.
  - If a set and a clear hit the same bit in one cycle, the set wins.
  - pending[0] is always 0.
  - ALU writes never touch pending.
- Reset mid-operation: all buffered MAC results are discarded and the pending scoreboard clears. Upstream units must be reset together with this block.
- Ordering: MAC results are written in arrival order. The ALU is never reordered relative to itself.

Decomposition:
- Shared package dsp_pkg holds:
  - REG_ADDR_W=4, NUM_REGS=16, DW=32;
  - a typedef for a write-request struct {rd, data};
  - the constant REG_ZERO=4'd0.
- Natural sub-module: dsp_wb_fifo, a parameterised synchronous FIFO with push/pop/full/empty/count and a first-word-fall-through head.
- The arbiter, starve counter, output register and scoreboard stay in dsp_writeback.

Test Plan:
- Reset, then ALU-only: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF -> next cycle we=1, rw=5, wdata=0xDEADBEEF; after reset all outputs are 0.
- MAC-only with scoreboard: issue r7; 3 cycles later mac_valid, rd=7, data=0x12345678 -> pending[7]=1 from issue+1; the write appears the cycle after the push+pop; pending[7]=0 on the same edge that we=1.
- Contention and starvation with STARVE_LIMIT=3: the FIFO holds one entry while alu_valid is high continuously -> the ALU wins 3 cycles, then alu_ready=0 for one cycle and the MAC entry is written; the ALU resumes the following cycle.
- FIFO full, DEPTH=4: push 5 MAC results while the ALU saturates the port -> mac_ready drops after 4; the 5th is held and accepted after the first pop; all 5 are written in order with correct data.
- r0 write: ALU rd=0, data=0xFFFFFFFF -> alu_ready=1, we stays 0. A MAC rd=0 entry pops with we=0; pending stays 0.
- Simultaneous set/clear plus reset: issue r3 in the same cycle a MAC r3 result pops -> pending[3]=1 afterwards. Then rst_n=0 with 2 entries buffered -> fifo_count=0, pending=0, we=0 next cycle.
